// File: rtl/motor_hbridge_driver.sv
// motor_hbridge_driver: two H-bridge channels with PWM speed and break-before-make dead time.
// Optional soft-start ramp of the per-channel duty when MOTOR_RAMP_EN is defined.
module motor_hbridge_driver #(
   parameter int DUTY_W      = 5,
   parameter int PRESCALE    = 4,
   parameter int DEAD_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        cmd_a,
   input  logic [1:0]        cmd_b,
   input  logic [DUTY_W-1:0] duty,
   output logic [1:0]        a_out,
   output logic [1:0]        b_out,
   output logic              dead_a,
   output logic              dead_b,
   output logic              pwm_tick
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;

   typedef enum logic [2:0] {COAST, DEAD, FWD, REV, BRAKE} state_t;

   logic [PW-1:0]     r_pre;
   logic [DUTY_W-1:0] r_cnt;
   logic              r_tick;
   logic              w_cnt_en;
   logic              w_wrap;
   logic [1:0]        w_cmd [2];
   logic              w_pwm [2];
   state_t            r_st  [2];
   logic [DW-1:0]     r_dc  [2];
   logic [1:0]        r_tgt [2];
   logic [1:0]        r_out [2];

   function automatic state_t f_tgt(input logic [1:0] cmd);
      return cmd == 2'b10 ? FWD : cmd == 2'b01 ? REV : BRAKE;
   endfunction

   assign w_cnt_en = r_pre == PW'(PRESCALE - 1);
   assign w_wrap   = w_cnt_en && (r_cnt == '1);
   assign w_cmd[0] = cmd_a;
   assign w_cmd[1] = cmd_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre  <= '0;
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_pre  <= w_cnt_en ? '0 : r_pre + 1'b1;
         r_cnt  <= w_cnt_en ? r_cnt + 1'b1 : r_cnt;
         r_tick <= w_wrap;
      end
   end

`ifdef MOTOR_RAMP_EN
   logic [DUTY_W-1:0] r_dq [2];
   logic              w_enter [2];

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         w_pwm[c]   = r_cnt < r_dq[c];
         w_enter[c] = r_st[c] == DEAD && w_cmd[c] == r_tgt[c] && r_dc[c] == '0 && r_tgt[c] != 2'b11;
      end
   end

   // Entering FWD/REV restarts the ramp from zero so the motor soft-starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) r_dq[c] <= '0;
      end else begin
         for (int c = 0; c < 2; c++)
            r_dq[c] <= w_enter[c] ? '0 :
                       !w_wrap ? r_dq[c] :
                       r_dq[c] < duty ? r_dq[c] + 1'b1 :
                       r_dq[c] > duty ? r_dq[c] - 1'b1 : r_dq[c];
      end
   end
`else
   logic [DUTY_W-1:0] r_duty;

   always_comb begin
      for (int c = 0; c < 2; c++) w_pwm[c] = r_cnt < r_duty;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_duty <= '0;
      else if (w_wrap) r_duty <= duty;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            r_st[c]  <= COAST;
            r_dc[c]  <= '0;
            r_tgt[c] <= 2'b00;
            r_out[c] <= 2'b00;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            r_out[c] <= r_st[c] == FWD   ? {w_pwm[c], 1'b0} :
                        r_st[c] == REV   ? {1'b0, w_pwm[c]} :
                        r_st[c] == BRAKE ? 2'b11 : 2'b00;
            case (r_st[c])
               COAST: begin
                  if (w_cmd[c] != 2'b00) begin
                     r_st[c]  <= DEAD;
                     r_dc[c]  <= DW'(DEAD_CYCLES - 1);
                     r_tgt[c] <= w_cmd[c];
                  end
               end
               DEAD: begin
                  if (w_cmd[c] == 2'b00) r_st[c] <= COAST;
                  else if (w_cmd[c] != r_tgt[c]) begin
                     r_dc[c]  <= DW'(DEAD_CYCLES - 1);
                     r_tgt[c] <= w_cmd[c];
                  end else if (r_dc[c] == '0) r_st[c] <= f_tgt(r_tgt[c]);
                  else r_dc[c] <= r_dc[c] - 1'b1;
               end
               default: begin
                  // Any change of non-coast command is forced back through DEAD.
                  if (w_cmd[c] == 2'b00) r_st[c] <= COAST;
                  else if (w_cmd[c] != r_tgt[c]) begin
                     r_st[c]  <= DEAD;
                     r_dc[c]  <= DW'(DEAD_CYCLES - 1);
                     r_tgt[c] <= w_cmd[c];
                  end
               end
            endcase
         end
      end
   end

   assign a_out    = r_out[0];
   assign b_out    = r_out[1];
   assign dead_a   = r_st[0] == DEAD;
   assign dead_b   = r_st[1] == DEAD;
   assign pwm_tick = r_tick;
endmodule

// File: doc/motor_hbridge_driver.md
Name: motor_hbridge_driver

Overview:
- Consumes the per-motor direction commands from the microbot navigation FSM and drives two H-bridge channels (A, B).
- Adds PWM speed control from a 5-bit duty word.
- Adds break-before-make dead time on every direction change, so the bridge never sees a shoot-through transition.
- Sits between the controller's motor bits and the pad outputs.

Parameters:
- DUTY_W, 5, width of duty input and PWM counter; PWM period = 2^DUTY_W counts.
- PRESCALE, 4, clk cycles per PWM count (≥1).
- DEAD_CYCLES, 8, clk cycles of forced coast between two different non-coast commands (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_a  in  2  channel A command {fwd, rev}: 00 coast, 10 forward, 01 reverse, 11 brake
- cmd_b  in  2  channel B command, same encoding
- duty  in  DUTY_W  requested duty, on-counts per PWM period
- a_out  out  2  channel A bridge inputs {in1, in2}, registered
- b_out  out  2  channel B bridge inputs {in1, in2}, registered
- dead_a  out  1  high while channel A is in DEAD
- dead_b  out  1  high while channel B is in DEAD
- pwm_tick  out  1  one-cycle pulse at PWM period wrap

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: a_out = b_out = 00; dead_a = dead_b = 0; pwm_tick = 0; prescaler = 0; PWM counter = 0; duty_q = 0; both channel FSMs = COAST.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - cnt_en = (prescaler == PRESCALE-1).
  - PWM counter increments on cnt_en and wraps 2^DUTY_W-1 → 0.
- pwm_tick:
  - Asserts for one cycle on the cycle where cnt_en is high and the counter is at 2^DUTY_W-1.
  - Is registered, so it is high the cycle after that condition.
- Duty sampling:
  - duty_q is loaded from duty only on the wrap (same cycle that sets pwm_tick).
  - Mid-period changes of duty have no effect until the next period.
- PWM level: pwm_on = (counter < duty_q).
  - duty_q = 0 → never on.
  - duty_q = 2^DUTY_W-1 → on 31/32 of the period.
- Per-channel FSM (A and B identical, independent). States: COAST, DEAD, FWD, REV, BRAKE.
  - COAST: out 00.
    - cmd 10, 01 or 11 → DEAD, load dead counter with DEAD_CYCLES-1, latch target = cmd.
  - DEAD: out 00, dead_x = 1; counter decrements each clk.
    - cmd 00 → COAST immediately.
    - cmd ≠ target and ≠ 00 → reload counter, target = cmd.
    - counter == 0 and cmd == target → target state (FWD / REV / BRAKE).
  - FWD: out {pwm_on, 0}. REV: out {0, pwm_on}. BRAKE: out 11, no PWM.
    - In any of these: cmd unchanged → stay; cmd 00 → COAST; any other cmd → DEAD (reload, new target).
- Outputs are registered from state plus pwm_on: one cycle after the state/counter.
- Latency:
  - cmd 00→10 sampled at edge k: dead_x high from edge k.
  - FWD entered at edge k+DEAD_CYCLES.
  - a_out first reflects FWD after edge k+DEAD_CYCLES+1.
- Invariant: a_out never goes 10↔01 or 1x↔x1 without at least DEAD_CYCLES cycles of 00 in between.
- Coast exit always goes through DEAD, covering coast durations shorter than the dead time.
- Reset mid-operation: asynchronous clear of all state; outputs drop to 00 immediately, without waiting for a clock.

Optional Feature:
- Macro: MOTOR_RAMP_EN.
- Defined: soft-start ramp.
  - At each wrap, duty_q moves one step toward duty (+1 if below, -1 if above, hold if equal) instead of jumping.
  - On any FSM transition into FWD/REV, that channel's effective duty restarts from 0 and ramps.
  - This requires a per-channel duty_q.
- Not defined: single shared duty_q loaded directly from duty at each wrap, exactly as in Behaviour.

Test Plan:
- PRESCALE=1, DUTY_W=5, DEAD_CYCLES=8; reset; cmd_a=10, duty=16 held → dead_a high 8 cycles; then a_out[1] toggles 16 high / 16 low per 32-cycle period; a_out[0]=0 throughout.
- While cmd_a=10 at steady state, switch to cmd_a=01 → a_out=00 for ≥8 cycles, then a_out[0] pulses; never 11 or any 10→01 adjacency.
- cmd_b=11 from COAST → b_out=00 for 8 cycles, then constant 11; cmd_b=00 → b_out=00 one cycle later, no dead phase.
- During DEAD toggle cmd_a 10→01 at dead count 3 → counter reloads; FWD never entered; REV entered 8 cycles after the change.
- Change duty 8→24 mid-period → duty cycle unchanged until the next pwm_tick, then 24/32; duty=0 → a_out[1] stays 0 in FWD.
- Assert rst_n=0 asynchronously mid-FWD-pulse → a_out, b_out = 00 before the next clk edge. With MOTOR_RAMP_EN: duty 0→4 gives on-counts 1, 2, 3, 4 over four periods.
